// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer handlers: Gray coding and depth derivation.
package fifo_pkg;

  localparam int unsigned MAX_W = 32;

  function automatic int unsigned fifo_depth(input int unsigned ptr_w);
    return 32'(1) << (ptr_w - 1);
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits keep narrower pointers intact.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module gray_sync #(
  parameter int unsigned P_W   = 4,
  parameter int unsigned P_STG = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [P_W-1:0] d,
  output logic [P_W-1:0] q
);

  logic [P_W-1:0] stg_q [P_STG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(P_STG); i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      stg_q[0] <= d;
      for (int i = 1; i < int'(P_STG); i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign q = stg_q[P_STG-1];

endmodule

// File: rtl/wptr_full_handler.sv
// Write-side pointer handler: binary/Gray write pointers, synchronized read pointer,
// full / almost-full / fill level and a sticky overflow flag.
module wptr_full_handler
  import fifo_pkg::*;
#(
  parameter int unsigned P_PTR_W    = 4,
  parameter int unsigned P_SYNC_STG = 2,
  parameter int unsigned P_AFULL_TH = 6
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic               i_w_en,
  input  logic [P_PTR_W-1:0] i_g_rptr,
  input  logic               i_ovf_clr,
  output logic               o_w_inc,
  output logic [P_PTR_W-1:0] o_b_wptr,
  output logic [P_PTR_W-1:0] o_g_wptr,
  output logic               o_full,
  output logic               o_afull,
  output logic [P_PTR_W-1:0] o_wlevel,
  output logic               o_ovf
);

  localparam int unsigned W = P_PTR_W;
  localparam logic [W-1:0] AFULL_TH = W'(P_AFULL_TH);

  logic [W-1:0] rptr_s;
  logic [W-1:0] rbin_s;
  logic [W-1:0] b_nxt;
  logic [W-1:0] g_nxt;
  logic [W-1:0] lvl_nxt;
  logic         full_nxt;
  logic         afull_nxt;
  logic         ovf_nxt;

  gray_sync #(
    .P_W   (W),
    .P_STG (P_SYNC_STG)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (i_g_rptr),
    .q     (rptr_s)
  );

  // Gated by reset so no RAM write can slip through while the block is held in reset.
  assign o_w_inc = i_w_en & ~o_full & wrst_n;

  always_comb begin
    b_nxt     = o_b_wptr + W'(o_w_inc);
    g_nxt     = W'(bin2gray(MAX_W'(b_nxt)));
    rbin_s    = W'(gray2bin(MAX_W'(rptr_s)));
    lvl_nxt   = b_nxt - rbin_s;
    full_nxt  = (g_nxt == {~rptr_s[W-1:W-2], rptr_s[W-3:0]});
    afull_nxt = (lvl_nxt >= AFULL_TH);
    ovf_nxt   = o_ovf;
    if (i_ovf_clr) begin
      ovf_nxt = 1'b0;
    end
    if (i_w_en && o_full) begin
      ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      o_b_wptr <= '0;
      o_g_wptr <= '0;
      o_full   <= 1'b0;
      o_afull  <= 1'b0;
      o_wlevel <= '0;
      o_ovf    <= 1'b0;
    end else begin
      o_b_wptr <= b_nxt;
      o_g_wptr <= g_nxt;
      o_full   <= full_nxt;
      o_afull  <= afull_nxt;
      o_wlevel <= lvl_nxt;
      o_ovf    <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_wptr_full_handler.sv
// Self-checking bench for wptr_full_handler: directed vector table plus randomized
// writer/reader traffic checked against a count-based reference model.
module tb_wptr_full_handler;

  localparam int W   = 4;
  localparam int D   = 8;
  localparam int TH  = 6;
  localparam int STG = 2;

  logic         wclk = 1'b0;
  logic         wrst_n;
  logic         i_w_en;
  logic [W-1:0] i_g_rptr;
  logic         i_ovf_clr;
  logic         o_w_inc;
  logic [W-1:0] o_b_wptr;
  logic [W-1:0] o_g_wptr;
  logic         o_full;
  logic         o_afull;
  logic [W-1:0] o_wlevel;
  logic         o_ovf;

  wptr_full_handler #(
    .P_PTR_W    (W),
    .P_SYNC_STG (STG),
    .P_AFULL_TH (TH)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .i_w_en    (i_w_en),
    .i_g_rptr  (i_g_rptr),
    .i_ovf_clr (i_ovf_clr),
    .o_w_inc   (o_w_inc),
    .o_b_wptr  (o_b_wptr),
    .o_g_wptr  (o_g_wptr),
    .o_full    (o_full),
    .o_afull   (o_afull),
    .o_wlevel  (o_wlevel),
    .o_ovf     (o_ovf)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [W-1:0] to_gray(input int n);
    int b;
    b = n % 16;
    return W'(b ^ (b >> 1));
  endfunction

  // Directed vectors: inputs held for one cycle, outputs checked after the edge
  typedef struct {
    logic         en;
    logic [W-1:0] rptr;
    logic         clr;
    logic         w_inc;
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         full;
    logic         afull;
    logic [W-1:0] lvl;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic [W-1:0] rptr, input logic clr,
                              input logic w_inc, input logic [W-1:0] b, input logic [W-1:0] g,
                              input logic full, input logic afull, input logic [W-1:0] lvl,
                              input logic ovf);
    vec_t v;
    v.en = en; v.rptr = rptr; v.clr = clr; v.w_inc = w_inc; v.b = b; v.g = g;
    v.full = full; v.afull = afull; v.lvl = lvl; v.ovf = ovf;
    vecs.push_back(v);
  endfunction

  // Reference model in terms of write/read counts and a delayed view of the read count
  int m_w, m_r, dly[$];
  bit m_full, m_afull, m_ovf;
  int m_lvl;

  task automatic m_reset();
    m_w = 0; m_r = 0; dly = '{0, 0};
    m_full = 0; m_afull = 0; m_ovf = 0; m_lvl = 0;
  endtask

  task automatic m_edge();
    int seen;
    bit acc;
    seen = dly.pop_front();
    dly.push_back(m_r);
    acc = i_w_en && !m_full;
    if (i_w_en && m_full) m_ovf = 1;
    else if (i_ovf_clr) m_ovf = 0;
    m_w   = m_w + int'(acc);
    m_lvl = m_w - seen;
    m_full  = (m_lvl == D);
    m_afull = (m_lvl >= TH);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_b"},     32'(o_b_wptr), 32'(m_w % 16));
    chk({tag, "_g"},     32'(o_g_wptr), 32'(to_gray(m_w)));
    chk({tag, "_full"},  32'(o_full),   32'(m_full));
    chk({tag, "_afull"}, 32'(o_afull),  32'(m_afull));
    chk({tag, "_lvl"},   32'(o_wlevel), 32'(m_lvl));
    chk({tag, "_ovf"},   32'(o_ovf),    32'(m_ovf));
  endtask

  bit saw_bwrap, saw_gwrap;

  task automatic run_random(input int n);
    logic [W-1:0] pb, pg;
    for (int i = 0; i < n; i++) begin
      i_w_en    = ($urandom_range(0, 3) != 0);
      i_ovf_clr = ($urandom_range(0, 19) == 0);
      #1;
      chk("rnd_w_inc", 32'(o_w_inc), 32'(i_w_en && !m_full));
      pb = o_b_wptr;
      pg = o_g_wptr;
      m_edge();
      tick();
      check_model("rnd");
      if (pb == 4'd15 && o_b_wptr == 4'd0) saw_bwrap = 1;
      if (pg == 4'b1000 && o_g_wptr == 4'b0000) saw_gwrap = 1;
      if (m_r < m_w && $urandom_range(0, 9) < 5) m_r++;
      i_g_rptr = to_gray(m_r);
    end
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    i_w_en = 1'b0; i_ovf_clr = 1'b0; i_g_rptr = '0;
    m_reset();
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [W-1:0] gtab [9];
    gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
             4'b0111, 4'b0101, 4'b0100, 4'b1100};

    // Idle after reset
    for (int i = 0; i < 5; i++) add(0, 4'h0, 0, 0, 4'd0, 4'b0000, 0, 0, 4'd0, 0);
    // Eight writes fill the FIFO
    for (int k = 1; k <= 8; k++)
      add(1, 4'h0, 0, 1, W'(k), gtab[k], (k == 8), (k >= 6), W'(k), 0);
    // Writes while full are dropped and flag overflow
    add(1, 4'h0, 0, 0, 4'd8, 4'b1100, 1, 1, 4'd8, 1);
    add(1, 4'h0, 0, 0, 4'd8, 4'b1100, 1, 1, 4'd8, 1);
    add(0, 4'h0, 0, 0, 4'd8, 4'b1100, 1, 1, 4'd8, 1);
    add(1, 4'h0, 1, 0, 4'd8, 4'b1100, 1, 1, 4'd8, 1);
    add(0, 4'h0, 1, 0, 4'd8, 4'b1100, 1, 1, 4'd8, 0);
    // Read pointer steps to 1: full releases on the third edge
    add(0, 4'b0001, 0, 0, 4'd8, 4'b1100, 1, 1, 4'd8, 0);
    add(0, 4'b0001, 0, 0, 4'd8, 4'b1100, 1, 1, 4'd8, 0);
    add(0, 4'b0001, 0, 0, 4'd8, 4'b1100, 0, 1, 4'd7, 0);
    add(1, 4'b0001, 0, 1, 4'd9, 4'b1101, 1, 1, 4'd8, 0);

    do_reset();
    chk("rst_b", 32'(o_b_wptr), 0);
    chk("rst_g", 32'(o_g_wptr), 0);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_lvl", 32'(o_wlevel), 0);

    foreach (vecs[i]) begin
      i_w_en = vecs[i].en; i_g_rptr = vecs[i].rptr; i_ovf_clr = vecs[i].clr;
      #1;
      chk($sformatf("vec%0d_w_inc", i), 32'(o_w_inc), 32'(vecs[i].w_inc));
      tick();
      chk($sformatf("vec%0d_b", i),     32'(o_b_wptr), 32'(vecs[i].b));
      chk($sformatf("vec%0d_g", i),     32'(o_g_wptr), 32'(vecs[i].g));
      chk($sformatf("vec%0d_full", i),  32'(o_full),   32'(vecs[i].full));
      chk($sformatf("vec%0d_afull", i), 32'(o_afull),  32'(vecs[i].afull));
      chk($sformatf("vec%0d_lvl", i),   32'(o_wlevel), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d_ovf", i),   32'(o_ovf),    32'(vecs[i].ovf));
    end

    // Randomized traffic with pointer wrap
    do_reset();
    saw_bwrap = 0; saw_gwrap = 0;
    run_random(300);
    chk("wrap_b_seen", 32'(saw_bwrap), 1);
    chk("wrap_g_seen", 32'(saw_gwrap), 1);

    // Asynchronous reset in the middle of a burst, away from the clock edge
    i_w_en = 1'b1;
    #2;
    wrst_n = 1'b0;
    #1;
    chk("arst_w_inc", 32'(o_w_inc), 0);
    chk("arst_b", 32'(o_b_wptr), 0);
    chk("arst_g", 32'(o_g_wptr), 0);
    chk("arst_full", 32'(o_full), 0);
    chk("arst_afull", 32'(o_afull), 0);
    chk("arst_lvl", 32'(o_wlevel), 0);
    chk("arst_ovf", 32'(o_ovf), 0);
    do_reset();
    i_w_en = 1'b1;
    m_edge();
    tick();
    chk("post_rst_b", 32'(o_b_wptr), 1);
    chk("post_rst_g", 32'(o_g_wptr), 32'(4'b0001));
    i_w_en = 1'b0;

    run_random(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
